// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - configurable oversampling UART receiver with parity, stop-bit and break checks
// Delivers one word per frame on a one-cycle Rx_Done pulse with per-frame error flags.
module uart_frame_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 uart_rx,
    output logic                 Rx_Done,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Frame_Error,
    output logic                 Parity_Error,
    output logic                 Break_Detect
);

    localparam int DIV   = (CLOCK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int H     = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  T_S0      = OS_W'(H - 1);
    localparam logic [OS_W-1:0]  T_S1      = OS_W'(H);
    localparam logic [OS_W-1:0]  T_VOTE    = OS_W'(H + 1);
    localparam logic [OS_W-1:0]  T_END     = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  LAST_DATA = OS_W'(DATA_BITS - 1);
    localparam logic [OS_W-1:0]  LAST_STOP = OS_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;

    logic                 sync1_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [OS_W-1:0]      bit_q, bit_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 pbit_q, pbit_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 bd_q, bd_d;

    logic running, tick, fall, vote_pt, bit_end, vote, stop_err, last_stop;

    assign running   = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
    assign tick      = running && (div_q == DIV_LAST);
    assign fall      = rx_prev_q & ~rx_s_q;
    assign vote_pt   = tick && (os_q == T_VOTE);
    assign bit_end   = tick && (os_q == T_END);
    // Third sample is taken live at the vote tick, so no extra cycle of latency.
    assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign stop_err  = ferr_q | ~vote;
    assign last_stop = (state_q == S_STOP) && (bit_q == LAST_STOP) && vote_pt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (fall) state_d = S_START;
            S_START: begin
                if (vote_pt && vote) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_q == LAST_DATA)) begin
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY:    if (bit_end) state_d = S_STOP;
            // A clean frame rearms at mid-stop so a following start bit is never missed.
            S_STOP:      if (last_stop) state_d = stop_err ? S_WAIT_IDLE : S_IDLE;
            S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d   = '0;
        os_d    = os_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        pbit_d  = pbit_q;
        done_d  = 1'b0;
        data_d  = data_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        bd_d    = bd_q;

        if (state_q == S_IDLE) begin
            os_d   = '0;
            bit_d  = '0;
            ferr_d = 1'b0;
            perr_d = 1'b0;
            pbit_d = 1'b0;
        end

        if (running) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        if (tick) begin
            os_d = (os_q == T_END) ? '0 : os_q + OS_W'(1);
            if (os_q == T_S0) smp_d[0] = rx_s_q;
            if (os_q == T_S1) smp_d[1] = rx_s_q;
        end

        case (state_q)
            S_START: if (bit_end) bit_d = '0;
            S_DATA: begin
                if (vote_pt) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_end) bit_d = (bit_q == LAST_DATA) ? '0 : bit_q + OS_W'(1);
            end
            S_PARITY: begin
                if (vote_pt) begin
                    perr_d = (^shift_q) ^ vote ^ PAR_ODD;
                    pbit_d = vote;
                end
            end
            S_STOP: begin
                if (vote_pt) ferr_d = stop_err;
                if (last_stop) begin
                    done_d = 1'b1;
                    data_d = shift_q;
                    fe_d   = stop_err;
                    pe_d   = perr_q;
                    bd_d   = stop_err & ~(|shift_q) & ~pbit_q;
                end else if (bit_end) begin
                    bit_d = bit_q + OS_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            os_q      <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            pbit_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            bd_q      <= 1'b0;
        end else begin
            sync1_q   <= uart_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
            div_q     <= div_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            pbit_q    <= pbit_d;
            done_q    <= done_d;
            data_q    <= data_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            bd_q      <= bd_d;
        end
    end

    assign Rx_Done      = done_q;
    assign Rx_Data      = data_q;
    assign Frame_Error  = fe_q;
    assign Parity_Error = pe_q;
    assign Break_Detect = bd_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed bench for uart_frame_rx in 8N1, 8E1 and 7O2 configurations
module tb_uart_frame_rx;

    localparam int BIT_NS = 8680;

    logic Clk = 1'b0;
    always #10 Clk = ~Clk;

    logic Reset_n;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    logic       done_a, fe_a, pe_a, bd_a;
    logic [7:0] data_a;
    logic       done_b, fe_b, pe_b, bd_b;
    logic [7:0] data_b;
    logic       done_c, fe_c, pe_c, bd_c;
    logic [6:0] data_c;

    int n_vec = 0;
    int n_err = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int base;
    logic [9:0] fr;

    uart_frame_rx u_a (
        .Clk(Clk), .Reset_n(Reset_n), .uart_rx(rx_a),
        .Rx_Done(done_a), .Rx_Data(data_a),
        .Frame_Error(fe_a), .Parity_Error(pe_a), .Break_Detect(bd_a)
    );

    uart_frame_rx #(.PARITY(2)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .uart_rx(rx_b),
        .Rx_Done(done_b), .Rx_Data(data_b),
        .Frame_Error(fe_b), .Parity_Error(pe_b), .Break_Detect(bd_b)
    );

    uart_frame_rx #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .Clk(Clk), .Reset_n(Reset_n), .uart_rx(rx_c),
        .Rx_Done(done_c), .Rx_Data(data_c),
        .Frame_Error(fe_c), .Parity_Error(pe_c), .Break_Detect(bd_c)
    );

    always @(negedge Clk) begin
        if (done_a) cnt_a = cnt_a + 1;
        if (done_b) cnt_b = cnt_b + 1;
        if (done_c) cnt_c = cnt_c + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int ln, input logic v);
        case (ln)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Bits go out bit 0 first; the line is left at the last bit value.
    task automatic send_raw(input int ln, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(ln, bits[i]);
            #(BIT_NS);
        end
    endtask

    task automatic idle(input int ln, input int nbits);
        set_line(ln, 1'b1);
        #(BIT_NS * nbits);
    endtask

    initial begin
        Reset_n = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        chk("rst_done", {15'h0, done_a}, 16'h0);
        chk("rst_data", {8'h0, data_a}, 16'h0);
        chk("rst_fe", {15'h0, fe_a}, 16'h0);
        chk("rst_pe", {15'h0, pe_a}, 16'h0);
        chk("rst_bd", {15'h0, bd_a}, 16'h0);
        chk("rst_c_data", {9'h0, data_c}, 16'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        #(BIT_NS * 2);

        fork
            begin
                send_raw(0, {6'h0, 1'b1, 8'hAA, 1'b0}, 10);
                idle(0, 10);
                chk("b1_data", {8'h0, data_a}, 16'h00AA);
                chk("b1_fe", {15'h0, fe_a}, 16'h0);
                chk("b1_cnt", 16'(cnt_a), 16'd1);
                send_raw(0, {6'h0, 1'b1, 8'hCC, 1'b0}, 10);
                idle(0, 10);
                chk("b2_data", {8'h0, data_a}, 16'h00CC);
                chk("b2_pe", {15'h0, pe_a}, 16'h0);
                chk("b2_cnt", 16'(cnt_a), 16'd2);
                send_raw(0, {6'h0, 1'b1, 8'hBB, 1'b0}, 10);
                idle(0, 10);
                chk("b3_data", {8'h0, data_a}, 16'h00BB);
                chk("b3_bd", {15'h0, bd_a}, 16'h0);
                chk("b3_fe", {15'h0, fe_a}, 16'h0);
                chk("b3_cnt", 16'(cnt_a), 16'd3);
            end
            begin
                send_raw(1, {4'h0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
                idle(1, 2);
                chk("ep_ok_data", {8'h0, data_b}, 16'h0007);
                chk("ep_ok_pe", {15'h0, pe_b}, 16'h0);
                chk("ep_ok_fe", {15'h0, fe_b}, 16'h0);
                chk("ep_ok_cnt", 16'(cnt_b), 16'd1);
                send_raw(1, {4'h0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
                idle(1, 2);
                chk("ep_bad_data", {8'h0, data_b}, 16'h0007);
                chk("ep_bad_pe", {15'h0, pe_b}, 16'h1);
                chk("ep_bad_fe", {15'h0, fe_b}, 16'h0);
                chk("ep_bad_cnt", 16'(cnt_b), 16'd2);
            end
            begin
                send_raw(2, {5'h0, 1'b1, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
                idle(2, 2);
                chk("7o2_data", {9'h0, data_c}, 16'h0041);
                chk("7o2_pe", {15'h0, pe_c}, 16'h0);
                chk("7o2_fe", {15'h0, fe_c}, 16'h0);
                chk("7o2_cnt", 16'(cnt_c), 16'd1);
                send_raw(2, {5'h0, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
                idle(2, 2);
                chk("7o2_stop2_fe", {15'h0, fe_c}, 16'h1);
                chk("7o2_stop2_bd", {15'h0, bd_c}, 16'h0);
                chk("7o2_stop2_data", {9'h0, data_c}, 16'h0041);
                chk("7o2_stop2_cnt", 16'(cnt_c), 16'd2);
                set_line(2, 1'b0);
                #(BIT_NS * 22);
                idle(2, 3);
                chk("brk_fe", {15'h0, fe_c}, 16'h1);
                chk("brk_bd", {15'h0, bd_c}, 16'h1);
                chk("brk_pe", {15'h0, pe_c}, 16'h1);
                chk("brk_data", {9'h0, data_c}, 16'h0);
                chk("brk_cnt", 16'(cnt_c), 16'd3);
            end
        join

        base = cnt_a;
        send_raw(0, {6'h0, 1'b0, 8'hF0, 1'b0}, 10);
        set_line(0, 1'b0);
        #(BIT_NS * 19);
        chk("fe_cnt", 16'(cnt_a - base), 16'd1);
        chk("fe_data", {8'h0, data_a}, 16'h00F0);
        chk("fe_flag", {15'h0, fe_a}, 16'h1);
        chk("fe_bd", {15'h0, bd_a}, 16'h0);
        idle(0, 2);
        send_raw(0, {6'h0, 1'b1, 8'h55, 1'b0}, 10);
        idle(0, 2);
        chk("after_fe_cnt", 16'(cnt_a - base), 16'd2);
        chk("after_fe_data", {8'h0, data_a}, 16'h0055);
        chk("after_fe_flag", {15'h0, fe_a}, 16'h0);

        base = cnt_a;
        set_line(0, 1'b0);
        #1000;
        idle(0, 3);
        chk("glitch_cnt", 16'(cnt_a - base), 16'd0);
        fr = {1'b1, 8'h3C, 1'b0};
        send_raw(0, {6'h0, fr}, 4);
        set_line(0, 1'b1);
        #(BIT_NS / 2 - 50);
        set_line(0, 1'b0);
        #100;
        set_line(0, 1'b1);
        #(BIT_NS / 2 - 50);
        send_raw(0, {11'h0, fr[9:5]}, 5);
        idle(0, 2);
        chk("spike_data", {8'h0, data_a}, 16'h003C);
        chk("spike_cnt", 16'(cnt_a - base), 16'd1);

        base = cnt_a;
        fr = {1'b1, 8'hA5, 1'b0};
        send_raw(0, {6'h0, fr}, 5);
        set_line(0, fr[5]);
        #(BIT_NS / 2);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_data", {8'h0, data_a}, 16'h0);
        chk("mid_rst_done", {15'h0, done_a}, 16'h0);
        chk("mid_rst_c_fe", {15'h0, fe_c}, 16'h0);
        chk("mid_rst_c_bd", {15'h0, bd_c}, 16'h0);
        #100;
        set_line(0, 1'b1);
        #103;
        Reset_n = 1'b1;
        idle(0, 3);
        chk("mid_rst_cnt", 16'(cnt_a - base), 16'd0);
        send_raw(0, {6'h0, fr}, 10);
        idle(0, 2);
        chk("post_rst_data", {8'h0, data_a}, 16'h00A5);
        chk("post_rst_fe", {15'h0, fe_a}, 16'h0);
        chk("post_rst_cnt", 16'(cnt_a - base), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Configurable UART receiver: the parametrised successor to the fixed 8N1 byte receiver. It adds selectable data width, parity, stop-bit count, 16x oversampling with 3-sample majority voting, false-start rejection and break detection. It sits between the board RX pin and the command parser that feeds the TFT display controller, and it delivers one word per frame with per-frame error flags.

## Interface
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- OVERSAMPLE, 16, sample ticks per bit, even, ≥8
- Clk  in  1  system clock; all logic on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- uart_rx  in  1  asynchronous serial line, idle high
- Rx_Done  out  1  one-cycle pulse when a frame completes, including frames with errors
- Rx_Data  out  DATA_BITS  received word, updated only with Rx_Done
- Frame_Error  out  1  a stop bit was sampled 0; valid with Rx_Done and held until the next Rx_Done
- Parity_Error  out  1  parity mismatch; always 0 when PARITY=0; same validity as Frame_Error
- Break_Detect  out  1  Frame_Error with all data bits and the parity bit 0; same validity as Frame_Error

## Operation
- **Synchroniser.** uart_rx passes through a 2-FF synchroniser to give rx_s. Both flops reset to 1.
- **Tick generator.**
  - DIV = round(CLOCK_FREQ/(BAUD*OVERSAMPLE)).
  - The counter is held at 0 in IDLE and WAIT_IDLE and is cleared on start detection.
  - A tick fires when the counter reaches DIV-1; the counter then wraps to 0.
- **Per-bit sampling.**
  - A tick counter (0..OVERSAMPLE-1) runs within each bit.
  - rx_s is sampled at ticks H-1, H and H+1, where H = OVERSAMPLE/2.
  - The bit value is the majority of the three samples.
  - The bit ends at tick OVERSAMPLE-1.
- **States.** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: a falling edge of rx_s (previous 1, now 0) moves to START.
  - START: at the majority point, a voted 1 is a false start; return to IDLE with no output. At the end of the bit, go to DATA.
  - DATA: shift the voted bits LSB first. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: compare the voted bit with the expected parity. Odd means the XOR of data and parity is 1; even means it is 0.
  - STOP: evaluate STOP_BITS bits, with any voted 0 setting the frame error. On the last stop bit, evaluation is taken at its majority point, not the end of the bit. At that point pulse Rx_Done and load Rx_Data and all three flags.
    - Clean frame: go to IDLE at once, so a start bit arriving after half a stop bit is still caught.
    - Frame_Error frame: go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. A held-low line never produces repeated frames.
- **Rx_Done on error.** Rx_Done is asserted for good and errored frames alike; the consumer uses the flags to qualify the data.
- **Reset mid-frame.** All state, counters and outputs clear immediately. After reset is released, a line that is already low is not a start: an edge is required, and the synchroniser resets to 1.
- **Widths.** The tick counter is clog2(DIV) bits. Both the per-bit tick counter and the bit counter are clog2(OVERSAMPLE) bits. The shift register is DATA_BITS bits.

## Timing
- **Reset values:** Rx_Done 0, Rx_Data 0, Frame_Error 0, Parity_Error 0, Break_Detect 0, state IDLE.
- **Start-detection latency:** 2 cycles from an uart_rx falling edge to START entry, plus 1 cycle for the edge register.
- **Rx_Done timing:** registered. It fires 1 cycle after the tick H+1 of the last stop bit. That is about (1 + DATA_BITS + P + STOP_BITS − 0.5) bit periods after the start edge, where P = 1 if PARITY≠0, else 0.
- **Data and flags:** Rx_Data and all flags change only in the same cycle Rx_Done goes high, and are stable otherwise.
- **Baud error:** tolerance is at least ±3% with 16x oversampling.

## Test plan
Bench settings unless stated: 50 MHz clock, 115200 baud, DIV = 27, bit time 8680 ns.

1. **8N1 burst.** Send 0xAA, 0xCC, 0xBB, each followed by 10 idle bits → three Rx_Done pulses, data 0xAA, 0xCC, 0xBB, all flags 0.
2. **Frame error and held-low line.** Send 0xF0 with a 0 stop bit, keep the line low for 20 bit times, release, then send 0x55 → exactly one Rx_Done with 0xF0 and Frame_Error=1, then one Rx_Done with 0x55 and flags 0.
3. **Even parity (PARITY=2).**
   - Send 0x07 with parity bit 1 → Parity_Error=0.
   - Send 0x07 with parity bit 0 → Rx_Done with Parity_Error=1 and Rx_Data=0x07.
4. **Glitch rejection.**
   - A 1 µs low pulse on an idle line → no Rx_Done.
   - A 100 ns inverted spike at the centre of data bit 3 of 0x3C → Rx_Data=0x3C.
5. **Reset mid-frame.** Assert Reset_n low during data bit 4 → all outputs 0 in the same cycle, no Rx_Done. After release, send 0xA5 → received correctly.
6. **7O2 and break (DATA_BITS=7, PARITY=1, STOP_BITS=2).**
   - Send 0x41 with correct parity → flags 0.
   - Send 0x41 with a 0 second stop bit → Frame_Error=1.
   - Hold the line low for 2 frame times → Frame_Error=1, Break_Detect=1, Rx_Data=0, one pulse only.
